// File: rtl/incr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : incr_pipe
// Brief    : Two-stage pipelined +/-1 incrementer/decrementer with block
//            carry-lookahead and valid/ready handshakes on both sides.
//            Optional macro INCR_SAT_EN saturates the result on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module incr_pipe #(
  parameter int WIDTH = 24,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic             cin,
  input  logic             dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero
);

  localparam int c_nblk = WIDTH / BLK;

  logic              r_s1_valid;
  logic [WIDTH-1:0]  r_s1_a;
  logic              r_s1_cin;
  logic              r_s1_dec;
  logic [c_nblk-1:0] r_s1_grp;

  logic              r_s2_valid;
  logic [WIDTH-1:0]  r_s;
  logic              r_cout;
  logic              r_zero;

  logic              w_adv;
  logic [c_nblk-1:0] w_grp;
  logic [c_nblk-1:0] w_blk_cin;
  logic [WIDTH-1:0]  w_match;
  logic [WIDTH-1:0]  w_carry_in;
  logic [WIDTH-1:0]  w_sum;
  logic [WIDTH-1:0]  w_res;
  logic              w_cout;

  // Both stages move together whenever stage 2 is free or being drained.
  assign w_adv    = ~r_s2_valid | out_ready;
  assign in_ready = ~r_s1_valid | w_adv;

  // Group signal: block would propagate the carry (all ones) or borrow (all zeros).
  generate
    for (genvar k = 0; k < c_nblk; k++) begin : g_grp
      assign w_grp[k] = dec ? ~|a[k*BLK +: BLK] : &a[k*BLK +: BLK];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_dec   <= 1'b0;
      r_s1_grp   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= a;
        r_s1_cin <= cin;
        r_s1_dec <= dec;
        r_s1_grp <= w_grp;
      end
    end
  end

  assign w_match = r_s1_dec ? ~r_s1_a : r_s1_a;

  always_comb begin
    w_blk_cin = '0;
    for (int k = 0; k < c_nblk; k++) begin
      logic acc;
      acc = r_s1_cin;
      for (int j = 0; j < k; j++) begin
        acc = acc & r_s1_grp[j];
      end
      w_blk_cin[k] = acc;
    end
  end

  // Within a block, the carry into bit i needs every lower bit of the block to match.
  always_comb begin
    w_carry_in = '0;
    for (int k = 0; k < c_nblk; k++) begin
      for (int i = 0; i < BLK; i++) begin
        logic acc;
        acc = w_blk_cin[k];
        for (int j = 0; j < i; j++) begin
          acc = acc & w_match[k*BLK + j];
        end
        w_carry_in[k*BLK + i] = acc;
      end
    end
  end

  assign w_sum  = r_s1_a ^ w_carry_in;
  assign w_cout = r_s1_cin & (&r_s1_grp);

`ifdef INCR_SAT_EN
  assign w_res = w_cout ? (r_s1_dec ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s        <= '0;
      r_cout     <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s    <= w_res;
        r_cout <= w_cout;
        r_zero <= ~|w_res;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign zero      = r_zero;

endmodule
`default_nettype wire
